// File: rtl/memory_access_unit_if.sv
// Data-memory req/ack port shared by the MEM-stage sequencer and the memory.
// The unit drives the request side; the memory answers with ack and read data.
interface memory_access_unit_if #(
    parameter int N = 64
);
    logic         dm_req;
    logic         dm_we;
    logic [N-1:0] dm_addr;
    logic [N-1:0] dm_wdata;
    logic [N-1:0] dm_rdata;
    logic         dm_ack;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ack
    );
endinterface

// File: rtl/memory_access_unit.sv
// MEM-stage load/store sequencer: req/ack data port, stall, load data, PCSrc.
// Optional MEM_ALIGN_CHECK_EN: misaligned accesses skip memory, flag misalign_M.
module memory_access_unit #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         MemRead_M,
    input  logic         MemWrite_M,
    input  logic         Branch_M,
    input  logic         zero_M,
    input  logic [N-1:0] aluResult_M,
    input  logic [N-1:0] writeData_M,
    input  logic [N-1:0] PCBranch_M,
    output logic         PCSrc_M,
    output logic [N-1:0] PCBranchOut,
    output logic [N-1:0] readData_M,
    output logic         done_M,
    output logic         stall_M,
`ifdef MEM_ALIGN_CHECK_EN
    output logic         misalign_M,
`endif
    memory_access_unit_if.master dm
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    state_e       state_q;
    logic         req_q;
    logic         we_q;
    logic [N-1:0] addr_q;
    logic [N-1:0] wdata_q;
    logic [N-1:0] rdata_q;
    logic         done_q;
    logic         op;
    logic         misal;

    assign op = MemRead_M | MemWrite_M;

`ifdef MEM_ALIGN_CHECK_EN
    logic mis_q;
    assign misal      = |aluResult_M[2:0];
    assign misalign_M = mis_q;
`else
    assign misal = 1'b0;
`endif

    // Branch resolution never waits on the memory access.
    assign PCSrc_M     = Branch_M & zero_M;
    assign PCBranchOut = PCBranch_M;

    assign stall_M = (state_q == ACCESS) || ((state_q == IDLE) && op);

    assign dm.dm_req   = req_q;
    assign dm.dm_we    = we_q;
    assign dm.dm_addr  = addr_q;
    assign dm.dm_wdata = wdata_q;
    assign readData_M  = rdata_q;
    assign done_M      = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (op && misal) begin
`ifdef MEM_ALIGN_CHECK_EN
                        mis_q <= 1'b1;
`endif
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (op) begin
                        addr_q  <= aluResult_M;
                        wdata_q <= writeData_M;
                        we_q    <= MemWrite_M;
                        req_q   <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (dm.dm_ack) begin
                        req_q <= 1'b0;
                        if (!we_q) rdata_q <= dm.dm_rdata;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                    mis_q  <= 1'b0;
`endif
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit: loads, stores, branch, reset, spurious ack.
// Define MEM_ALIGN_CHECK_EN to also cover the misaligned-access path.
module tb_memory_access_unit;
    localparam int N = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         MemRead_M, MemWrite_M, Branch_M, zero_M;
    logic [N-1:0] aluResult_M, writeData_M, PCBranch_M;
    logic         PCSrc_M;
    logic [N-1:0] PCBranchOut, readData_M;
    logic         done_M, stall_M;
`ifdef MEM_ALIGN_CHECK_EN
    logic         misalign_M;
`endif

    int checks   = 0;
    int failures = 0;

    memory_access_unit_if #(.N(N)) dmif ();

    memory_access_unit #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .MemRead_M   (MemRead_M),
        .MemWrite_M  (MemWrite_M),
        .Branch_M    (Branch_M),
        .zero_M      (zero_M),
        .aluResult_M (aluResult_M),
        .writeData_M (writeData_M),
        .PCBranch_M  (PCBranch_M),
        .PCSrc_M     (PCSrc_M),
        .PCBranchOut (PCBranchOut),
        .readData_M  (readData_M),
        .done_M      (done_M),
        .stall_M     (stall_M),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign_M  (misalign_M),
`endif
        .dm          (dmif.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got,
                         input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Results of the last do_op call.
    int           n_stall, n_done, req_cyc;
    logic         seen_we, seen_mis;
    logic [N-1:0] seen_addr, seen_wdata, rd_at_done;
    logic         pcs_bad;

    task automatic do_op(input logic rd, input logic wr,
                         input logic [N-1:0] addr, input logic [N-1:0] wd,
                         input int ack_dly, input logic [N-1:0] rdat);
        bit fin = 0;
        n_stall = 0; n_done = 0; req_cyc = -1;
        seen_we = 0; seen_addr = '0; seen_wdata = '0;
        seen_mis = 0; rd_at_done = '0; pcs_bad = 0;
        MemRead_M = rd; MemWrite_M = wr;
        aluResult_M = addr; writeData_M = wd;
        for (int c = 0; c < 20 && !fin; c++) begin
            @(negedge clk);
            if (PCSrc_M !== (Branch_M & zero_M)) pcs_bad = 1;
            if (PCBranchOut !== PCBranch_M) pcs_bad = 1;
            if (stall_M) n_stall++;
            if (dmif.dm_req) begin
                if (req_cyc < 0) req_cyc = c;
                seen_we = dmif.dm_we;
                seen_addr = dmif.dm_addr;
                seen_wdata = dmif.dm_wdata;
                if (c - req_cyc == ack_dly) begin
                    dmif.dm_ack = 1'b1;
                    dmif.dm_rdata = rdat;
                end
            end
            if (done_M) begin
                n_done++;
                rd_at_done = readData_M;
`ifdef MEM_ALIGN_CHECK_EN
                seen_mis = misalign_M;
`endif
                fin = 1;
            end
            @(posedge clk); #1;
            dmif.dm_ack = 1'b0;
            dmif.dm_rdata = '0;
        end
        if (!fin) check("op_timeout", 0, 1);
        MemRead_M = 0; MemWrite_M = 0;
        @(negedge clk);
        if (done_M) n_done++;
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1; MemRead_M = 0; MemWrite_M = 0;
        Branch_M = 0; zero_M = 0;
        aluResult_M = '0; writeData_M = '0; PCBranch_M = '0;
        dmif.dm_ack = 0; dmif.dm_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_req", dmif.dm_req, 0);
        check("rst_we", dmif.dm_we, 0);
        check("rst_addr", dmif.dm_addr, 0);
        check("rst_wdata", dmif.dm_wdata, 0);
        check("rst_rdata", readData_M, 0);
        check("rst_done", done_M, 0);
        check("rst_stall", stall_M, 0);
        @(posedge clk); #1;

        // Load at 0x40 with a taken branch riding along.
        Branch_M = 1; zero_M = 1; PCBranch_M = 64'h0000_0000_0000_1000;
        do_op(1, 0, 64'h40, 64'h0, 2, 64'hDEADBEEF_00000001);
        check("ld_stall", n_stall, 4);
        check("ld_done", n_done, 1);
        check("ld_addr", seen_addr, 64'h40);
        check("ld_we", seen_we, 0);
        check("ld_data", rd_at_done, 64'hDEADBEEF_00000001);
        check("ld_pcsrc", pcs_bad, 0);
        check("ld_hold", readData_M, 64'hDEADBEEF_00000001);
        Branch_M = 0;

        // Store 0x1234 to 0x80, ack in the first request cycle.
        do_op(0, 1, 64'h80, 64'h1234, 0, 64'h5555);
        check("st_stall", n_stall, 2);
        check("st_done", n_done, 1);
        check("st_we", seen_we, 1);
        check("st_addr", seen_addr, 64'h80);
        check("st_wdata", seen_wdata, 64'h1234);
        check("st_rdata", readData_M, 64'hDEADBEEF_00000001);

        // Read and write together: treated as a write.
        do_op(1, 1, 64'h88, 64'hABCD, 1, 64'h7777);
        check("rw_we", seen_we, 1);
        check("rw_stall", n_stall, 3);
        check("rw_rdata", readData_M, 64'hDEADBEEF_00000001);

        // Spurious ack while idle.
        dmif.dm_ack = 1; dmif.dm_rdata = 64'hBAD0;
        @(negedge clk);
        check("sp_stall", stall_M, 0);
        @(posedge clk); #1;
        dmif.dm_ack = 0;
        @(negedge clk);
        check("sp_done", done_M, 0);
        check("sp_req", dmif.dm_req, 0);
        check("sp_rdata", readData_M, 64'hDEADBEEF_00000001);
        @(posedge clk); #1;

        // Reset in the middle of an access; late ack must be ignored.
        MemRead_M = 1; aluResult_M = 64'h100;
        @(posedge clk); #1;
        @(negedge clk);
        check("ra_req", dmif.dm_req, 1);
        reset = 1; MemRead_M = 0;
        @(posedge clk); #1;
        reset = 0;
        dmif.dm_ack = 1; dmif.dm_rdata = 64'hBAD1;
        @(negedge clk);
        check("ra_req0", dmif.dm_req, 0);
        check("ra_stall", stall_M, 0);
        @(posedge clk); #1;
        dmif.dm_ack = 0;
        @(negedge clk);
        check("ra_done", done_M, 0);
        check("ra_rdata", readData_M, 0);
        @(posedge clk); #1;

        // Word-aligned load after reset still works.
        do_op(1, 0, 64'h200, 64'h0, 1, 64'h0123_4567_89AB_CDEF);
        check("ld2_data", readData_M, 64'h0123_4567_89AB_CDEF);
        check("ld2_mis", seen_mis, 0);

`ifdef MEM_ALIGN_CHECK_EN
        do_op(1, 0, 64'h43, 64'h0, 0, 64'h9999);
        check("mis_req", req_cyc, -1);
        check("mis_stall", n_stall, 1);
        check("mis_done", n_done, 1);
        check("mis_flag", seen_mis, 1);
        check("mis_rdata", readData_M, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        check("mis_clr", misalign_M, 0);
        @(posedge clk); #1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
